uart_cmd_ctrl: RTL and testbench



---
 rtl/uart_cmd_pkg.sv | 16 +
 rtl/cmd_timeout_cnt.sv | 31 +++
 rtl/uart_cmd_ctrl.sv | 142 ++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command sequencer: FSM encoding and defaults.
package uart_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_DATA = 2'd1,
    WR_REQ  = 2'd2,
    RD_REQ  = 2'd3
  } state_t;

  localparam logic [7:0] CMD_WR_DEF      = 8'h55;
  localparam logic [7:0] CMD_RD_DEF      = 8'hAA;
  localparam int         TIMEOUT_CYC_DEF = 13020;
  localparam int         CNT_W_DEF       = 16;

endpackage

// File: rtl/cmd_timeout_cnt.sv
// Inter-byte timeout counter. Counts cycles since the last clear while enabled.
// tc is asserted in the cycle whose increment would bring the count to
// TIMEOUT_CYC-1, so the caller's registered reaction lands exactly
// TIMEOUT_CYC cycles after the last clear. tc is suppressed by clr, which
// lets a byte arriving on the terminal cycle win over the timeout.
module cmd_timeout_cnt #(
  parameter int TIMEOUT_CYC = 13020,
  parameter int CNT_W       = 16
) (
  input  logic s_clk,
  input  logic s_rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 2);

  logic [CNT_W-1:0] cnt;

  // Idle-cycle count; holds at LAST since the owner leaves on tc.
  always_ff @(posedge s_clk) begin
    if (s_rst || clr)
      cnt <= '0;
    else if (en && cnt != LAST)
      cnt <= cnt + CNT_W'(1);
  end

  assign tc = en && !clr && (cnt == LAST);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Command sequencer: parses uart_rx bytes into write/read frames, streams
// write payload to the SDRAM write FIFO and issues req/ack requests to the
// SDRAM arbiter. Partial write frames are abandoned on inter-byte timeout.
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int         WR_LEN      = 4,
  parameter logic [7:0] CMD_WR      = CMD_WR_DEF,
  parameter logic [7:0] CMD_RD      = CMD_RD_DEF,
  parameter int         TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int         CNT_W       = CNT_W_DEF
) (
  input  logic       s_clk,
  input  logic       s_rst,
  input  logic       po_flag,
  input  logic [7:0] rx_data,
  output logic       wfifo_wr_en,
  output logic [7:0] wfifo_data,
  output logic       wfifo_clr,
  output logic       wr_req,
  input  logic       wr_ack,
  output logic       rd_req,
  input  logic       rd_ack,
  output logic       err_drop,
  output logic       err_timeout,
  output logic       busy
);

  localparam logic [7:0] LEN8 = 8'(WR_LEN);

  state_t     state, state_next;
  logic [7:0] bcnt, bcnt_next, bcnt_inc;
  logic       wfifo_wr_en_d, wfifo_clr_d, wr_req_d, rd_req_d;
  logic       err_drop_d, err_timeout_d;
  logic [7:0] wfifo_data_d;
  logic       to_en, to_clr, to_tc;

  // Timeout only runs inside a write frame; every received byte restarts it,
  // and being outside WR_DATA keeps it cleared so it starts fresh on entry.
  assign to_en  = (state == WR_DATA);
  assign to_clr = !to_en || po_flag;

  cmd_timeout_cnt #(
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .CNT_W      (CNT_W)
  ) u_timeout (
    .s_clk(s_clk),
    .s_rst(s_rst),
    .clr  (to_clr),
    .en   (to_en),
    .tc   (to_tc)
  );

  assign bcnt_inc = bcnt + 8'd1;

  // Next-state and next-output decode; outputs are registered below.
  always_comb begin
    state_next    = state;
    bcnt_next     = bcnt;
    wfifo_wr_en_d = 1'b0;
    wfifo_data_d  = wfifo_data;
    wfifo_clr_d   = 1'b0;
    wr_req_d      = 1'b0;
    rd_req_d      = 1'b0;
    err_drop_d    = 1'b0;
    err_timeout_d = 1'b0;
    case (state)
      IDLE: begin
        if (po_flag) begin
          if (rx_data == CMD_WR) begin
            state_next = WR_DATA;
            bcnt_next  = 8'd0;
          end else if (rx_data == CMD_RD) begin
            state_next = RD_REQ;
            rd_req_d   = 1'b1;
          end else begin
            err_drop_d = 1'b1;
          end
        end
      end
      WR_DATA: begin
        if (po_flag) begin
          wfifo_wr_en_d = 1'b1;
          wfifo_data_d  = rx_data;
          bcnt_next     = (bcnt == LEN8) ? bcnt : bcnt_inc;
          // Request goes out a cycle after the last FIFO write.
          if (bcnt_inc == LEN8)
            state_next = WR_REQ;
        end else if (to_tc) begin
          state_next    = IDLE;
          wfifo_clr_d   = 1'b1;
          err_timeout_d = 1'b1;
        end
      end
      WR_REQ: begin
        // Bytes are not buffered while a request is pending.
        err_drop_d = po_flag;
        // Ack only counts once the request is visible on the port.
        if (wr_req && wr_ack)
          state_next = IDLE;
        else
          wr_req_d = 1'b1;
      end
      RD_REQ: begin
        err_drop_d = po_flag;
        if (rd_req && rd_ack)
          state_next = IDLE;
        else
          rd_req_d = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  // State, byte counter and output registers.
  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      state       <= IDLE;
      bcnt        <= 8'd0;
      wfifo_wr_en <= 1'b0;
      wfifo_data  <= 8'h00;
      wfifo_clr   <= 1'b0;
      wr_req      <= 1'b0;
      rd_req      <= 1'b0;
      err_drop    <= 1'b0;
      err_timeout <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_next;
      bcnt        <= bcnt_next;
      wfifo_wr_en <= wfifo_wr_en_d;
      wfifo_data  <= wfifo_data_d;
      wfifo_clr   <= wfifo_clr_d;
      wr_req      <= wr_req_d;
      rd_req      <= rd_req_d;
      err_drop    <= err_drop_d;
      err_timeout <= err_timeout_d;
      busy        <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Scoreboard bench for uart_cmd_ctrl: stimulus pushes expected output events
// (with their expected cycle), a monitor pops and compares them as they appear.
module tb_uart_cmd_ctrl;

  localparam int T = 13020;

  logic       s_clk = 1'b0;
  logic       s_rst = 1'b1;
  logic       po_flag = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       wr_ack = 1'b0;
  logic       rd_ack = 1'b0;
  logic       wfifo_wr_en, wfifo_clr, wr_req, rd_req, err_drop, err_timeout, busy;
  logic [7:0] wfifo_data;

  always #5 s_clk = ~s_clk;

  uart_cmd_ctrl #(
    .WR_LEN(4), .CMD_WR(8'h55), .CMD_RD(8'hAA), .TIMEOUT_CYC(T), .CNT_W(16)
  ) dut (
    .s_clk(s_clk), .s_rst(s_rst), .po_flag(po_flag), .rx_data(rx_data),
    .wfifo_wr_en(wfifo_wr_en), .wfifo_data(wfifo_data), .wfifo_clr(wfifo_clr),
    .wr_req(wr_req), .wr_ack(wr_ack), .rd_req(rd_req), .rd_ack(rd_ack),
    .err_drop(err_drop), .err_timeout(err_timeout), .busy(busy)
  );

  typedef enum {EV_WR, EV_CT, EV_DROP, EV_WREQ, EV_RREQ} ev_e;
  typedef struct {
    ev_e kind;
    int  val;
    int  cyc;
  } ev_t;

  ev_t exp_q[$];
  int  cyc = 0;
  int  n_chk = 0;
  int  n_fail = 0;
  int  wr_dly = 0;
  int  rd_dly = 0;
  int  last_n = 0;

  always @(posedge s_clk) cyc <= cyc + 1;

  task automatic check(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_ev(ev_e k, int v, int c);
    ev_t e;
    e.kind = k; e.val = v; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic observe(ev_e k, int v, int c);
    ev_t e;
    n_chk++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_%s: got val %0h at cycle %0d, expected no event", k.name(), v, c);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.val != v || e.cyc != c) begin
        n_fail++;
        $display("FAIL event_%s: got %s val %0h cycle %0d, expected %s val %0h cycle %0d",
                 e.kind.name(), k.name(), v, c, e.kind.name(), e.val, e.cyc);
      end
    end
  endtask

  // Monitor: turns output activity into events and scores them.
  initial begin
    int   ws, rs;
    logic pw, pr;
    ws = 0; rs = 0; pw = 1'b0; pr = 1'b0;
    forever begin
      @(negedge s_clk);
      if (wfifo_wr_en === 1'b1) observe(EV_WR, int'(wfifo_data), cyc);
      if (wfifo_clr === 1'b1 || err_timeout === 1'b1)
        observe(EV_CT, int'({wfifo_clr, err_timeout}), cyc);
      if (err_drop === 1'b1) observe(EV_DROP, 0, cyc);
      if (wr_req === 1'b1 && !pw) ws = cyc;
      if (pw && wr_req !== 1'b1) observe(EV_WREQ, cyc - ws, ws);
      if (rd_req === 1'b1 && !pr) rs = cyc;
      if (pr && rd_req !== 1'b1) observe(EV_RREQ, cyc - rs, rs);
      if (wr_req === 1'b1 || rd_req === 1'b1)
        check("req_exclusive", int'(wr_req === 1'b1 && rd_req === 1'b1), 0);
      pw = (wr_req === 1'b1);
      pr = (rd_req === 1'b1);
    end
  end

  // Arbiter model: acks a request wr_dly/rd_dly cycles after it rises.
  initial begin
    int wk, rk;
    wk = 0; rk = 0;
    forever begin
      @(negedge s_clk);
      wr_ack = 1'b0;
      rd_ack = 1'b0;
      if (wr_req === 1'b1) begin
        if (wk == wr_dly) wr_ack = 1'b1;
        wk++;
      end else wk = 0;
      if (rd_req === 1'b1) begin
        if (rk == rd_dly) rd_ack = 1'b1;
        rk++;
      end else rk = 0;
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge s_clk);
    #1;
  endtask

  task automatic send(logic [7:0] b);
    po_flag = 1'b1;
    rx_data = b;
    last_n  = cyc;
    tick(1);
    po_flag = 1'b0;
  endtask

  task automatic send_wr(logic [7:0] b);
    send(b);
    expect_ev(EV_WR, int'(b), last_n + 1);
  endtask

  task automatic drain(int max, string name);
    for (int i = 0; i < max && exp_q.size() != 0; i++) tick(1);
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_wfifo_wr_en"}, int'(wfifo_wr_en), 0);
    check({tag, "_wfifo_data"},  int'(wfifo_data), 0);
    check({tag, "_wfifo_clr"},   int'(wfifo_clr), 0);
    check({tag, "_wr_req"},      int'(wr_req), 0);
    check({tag, "_rd_req"},      int'(rd_req), 0);
    check({tag, "_err_drop"},    int'(err_drop), 0);
    check({tag, "_err_timeout"}, int'(err_timeout), 0);
    check({tag, "_busy"},        int'(busy), 0);
  endtask

  initial begin
    int na;
    logic [7:0] b;

    // Reset state
    s_rst = 1'b1;
    tick(3);
    check_all_zero("reset");
    s_rst = 1'b0;
    tick(2);

    // 1: full write frame with 4340-cycle gaps, ack 2 cycles after req rises
    wr_dly = 2;
    send(8'h55);
    check("t1_busy", int'(busy), 1);
    for (int i = 1; i <= 4; i++) begin
      tick(4339);
      b = 8'(i);
      send_wr(b);
    end
    expect_ev(EV_WREQ, 3, last_n + 2);
    drain(50, "t1_drain");

    // 2: read command, ack 10 cycles after rd_req rises
    rd_dly = 10;
    tick(5);
    send(8'hAA);
    expect_ev(EV_RREQ, 11, last_n + 1);
    drain(50, "t2_drain");

    // 3: timeout after two payload bytes, then a normal frame
    tick(5);
    send(8'h55);
    tick(9); send_wr(8'h11);
    tick(9); send_wr(8'h22);
    expect_ev(EV_CT, 3, last_n + T);
    check("t3_busy_frame", int'(busy), 1);
    drain(T + 50, "t3_timeout");
    check("t3_busy_after", int'(busy), 0);
    wr_dly = 1;
    send(8'h55);
    for (int i = 0; i < 4; i++) begin
      tick(2);
      b = 8'hA1 + 8'(i);
      send_wr(b);
    end
    expect_ev(EV_WREQ, 2, last_n + 2);
    drain(50, "t3_drain");

    // 4: junk byte in IDLE, then byte during pending read
    tick(5);
    send(8'h3C);
    expect_ev(EV_DROP, 0, last_n + 1);
    check("t4_busy_idle", int'(busy), 0);
    rd_dly = 20;
    send(8'hAA);
    na = last_n;
    tick(2);
    send(8'h5A);
    expect_ev(EV_DROP, 0, last_n + 1);
    expect_ev(EV_RREQ, 21, na + 1);
    drain(60, "t4_drain");

    // 5: third payload byte on the terminal-count cycle; ack on first req cycle
    wr_dly = 0;
    tick(5);
    send(8'h55);
    tick(4); send_wr(8'hB1);
    tick(4); send_wr(8'hB2);
    tick(T - 2); send_wr(8'hB3);
    tick(4); send_wr(8'hB4);
    expect_ev(EV_WREQ, 1, last_n + 2);
    drain(50, "t5_drain");

    // 6: reset one cycle after the second payload byte, then a clean frame
    wr_dly = 2;
    tick(5);
    send(8'h55);
    tick(4); send_wr(8'hC1);
    tick(4); send_wr(8'hC2);
    s_rst = 1'b1;
    tick(1);
    check_all_zero("t6_rst");
    s_rst = 1'b0;
    tick(20);
    send(8'h55);
    for (int i = 5; i <= 8; i++) begin
      tick(3);
      b = 8'(i);
      send_wr(b);
    end
    expect_ev(EV_WREQ, 3, last_n + 2);
    drain(50, "t6_drain");

    tick(10);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
